// File: rtl/red_pkg.sv
// Shared types and constants for the RED nibble-reduction sequencer.
// RED_FLUSH_EN (optional) adds a flush input to red_seq_if and red_seq.
package red_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int NUM_PAIRS = 4;
  localparam int ACC_W     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } redState_t;

  function automatic int accumCycles(input int lanes);
    return NUM_PAIRS / lanes;
  endfunction

endpackage

// File: rtl/red_seq_if.sv
// Operand/result handshake bundle between the execute stage and red_seq.
// Carries the flush line only when RED_FLUSH_EN is defined.
interface red_seq_if #(
  parameter int RES_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_sum;
  logic             busy;
`ifdef RED_FLUSH_EN
  logic             flush;

  modport master (
    output in_valid, in_a, in_b, res_ready, flush,
    input  in_ready, res_valid, res_sum, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, res_ready, flush,
    output in_ready, res_valid, res_sum, busy
  );
`else
  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_sum, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_sum, busy
  );
`endif
endinterface

// File: rtl/red_lane_adder.sv
// Combinational slice: adds LANES nibble pairs onto the running accumulator.
// Purely combinational; all state lives in red_seq.
module red_lane_adder
  import red_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic [LANES*NIBBLE_W-1:0] nibA,
  input  logic [LANES*NIBBLE_W-1:0] nibB,
  input  logic [ACC_W-1:0]          accIn,
  output logic [ACC_W-1:0]          accOut
);

  always_comb begin
    accOut = accIn;
    for (int l = 0; l < LANES; l++) begin
      accOut = accOut + ACC_W'(nibA[l*NIBBLE_W +: NIBBLE_W])
                      + ACC_W'(nibB[l*NIBBLE_W +: NIBBLE_W]);
    end
  end

endmodule

// File: rtl/red_seq.sv
// Multi-cycle RED sequencer: sums all eight nibbles of two 16-bit operands
// through one LANES-wide adder slice. RED_FLUSH_EN adds an in-flight cancel.
//
//   state | meaning
//   IDLE  | ready for operands, in_ready high
//   ACCUM | adding LANES nibble pairs per edge into acc
//   DONE  | res_valid high, holding res_sum until res_ready
module red_seq
  import red_pkg::*;
#(
  parameter int LANES = 1,
  parameter int RES_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  red_seq_if.slave bus
);

  localparam int SEL_W = LANES * NIBBLE_W;
  localparam logic [1:0] LAST_IDX = 2'((accumCycles(LANES) - 1) * LANES);

  redState_t        state;
  logic             inReadyQ;
  logic             resValidQ;
  logic             busyQ;
  logic [RES_W-1:0] resSumQ;
  logic [1:0]       idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;
  logic [15:0]      opA;
  logic [15:0]      opB;
  logic [SEL_W-1:0] nibA;
  logic [SEL_W-1:0] nibB;
  logic             lastStep;
  logic             flushReq;

`ifdef RED_FLUSH_EN
  assign flushReq    = bus.flush;
  assign bus.in_ready = inReadyQ & ~bus.flush;
`else
  assign flushReq    = 1'b0;
  assign bus.in_ready = inReadyQ;
`endif

  assign bus.res_valid = resValidQ;
  assign bus.res_sum   = resSumQ;
  assign bus.busy      = busyQ;

  // Pair index wraps modulo 4; only in-range pairs are ever consumed.
  always_comb begin
    nibA = '0;
    nibB = '0;
    for (int l = 0; l < LANES; l++) begin
      nibA[l*NIBBLE_W +: NIBBLE_W] = opA[{idx + 2'(l), 2'b00} +: NIBBLE_W];
      nibB[l*NIBBLE_W +: NIBBLE_W] = opB[{idx + 2'(l), 2'b00} +: NIBBLE_W];
    end
  end

  assign lastStep = (idx == LAST_IDX);

  red_lane_adder #(
    .LANES (LANES)
  ) uLaneAdder (
    .nibA   (nibA),
    .nibB   (nibB),
    .accIn  (acc),
    .accOut (accNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inReadyQ  <= 1'b1;
      resValidQ <= 1'b0;
      resSumQ   <= '0;
      busyQ     <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      opA       <= '0;
      opB       <= '0;
    end else if (flushReq) begin
      state     <= IDLE;
      inReadyQ  <= 1'b1;
      resValidQ <= 1'b0;
      busyQ     <= 1'b0;
      idx       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && inReadyQ) begin
            opA      <= bus.in_a;
            opB      <= bus.in_b;
            acc      <= '0;
            idx      <= '0;
            inReadyQ <= 1'b0;
            busyQ    <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= accNext;
          idx <= idx + 2'(LANES);
          if (lastStep) begin
            resSumQ   <= RES_W'(accNext);
            resValidQ <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            resValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
            busyQ     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          resValidQ <= 1'b0;
          inReadyQ  <= 1'b1;
          busyQ     <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_seq.sv
// Bench for red_seq: three instances (LANES = 1, 2, 4) share one stimulus
// stream; vector table plus backpressure, async-reset and flush sequences.
module tb_red_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        resReady;
  logic [15:0] inA;
  logic [15:0] inB;
`ifdef RED_FLUSH_EN
  logic        flush;
`endif

  logic [2:0]       resValidV;
  logic [2:0]       inReadyV;
  logic [2:0]       busyV;
  logic [2:0][15:0] sumV;

  int nChecks = 0;
  int nFail   = 0;
  int latExp[3] = '{4, 2, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gLane
    red_seq_if #(.RES_W(16)) bus ();
    assign bus.in_valid  = inValid;
    assign bus.in_a      = inA;
    assign bus.in_b      = inB;
    assign bus.res_ready = resReady;
`ifdef RED_FLUSH_EN
    assign bus.flush     = flush;
`endif
    assign resValidV[g] = bus.res_valid;
    assign inReadyV[g]  = bus.in_ready;
    assign busyV[g]     = bus.busy;
    assign sumV[g]      = bus.res_sum;

    red_seq #(.LANES(1 << g), .RES_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          sum;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkLanes(input string name, input logic [2:0] act, input logic [2:0] exp);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_L%0d", name, 1 << k), int'(act[k]), int'(exp[k]));
  endtask

  task automatic checkSums(input string name, input int exp);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_L%0d", name, 1 << k), int'(sumV[k]), exp);
  endtask

  // Called #1 after a rising edge with all lanes idle; returns likewise.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input int expSum, input string tag);
    int lat[3];
    int seen[3];
    int busyCnt[3];
    checkLanes({tag, "_ready"}, inReadyV, 3'b111);
    inA = a;
    inB = b;
    inValid = 1'b1;
    resReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0;
      seen[k] = -1;
      busyCnt[k] = int'(busyV[k]);
    end
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        busyCnt[k] += int'(busyV[k]);
        if (resValidV[k] && lat[k] == 0) begin
          lat[k] = n;
          seen[k] = int'(sumV[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_lat_L%0d", tag, 1 << k), lat[k], latExp[k]);
      check($sformatf("%s_sum_L%0d", tag, 1 << k), seen[k], expSum);
      check($sformatf("%s_busy_L%0d", tag, 1 << k), busyCnt[k], latExp[k] + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vCount;

    vecs[0] = '{16'h1234, 16'h5678, 36};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 120};
    vecs[2] = '{16'h0000, 16'h0000, 0};
    vecs[3] = '{16'hF0F0, 16'h0F0F, 60};
    vecs[4] = '{16'h8421, 16'h1248, 30};
    vecs[5] = '{16'hABCD, 16'h0001, 47};

    rst_n = 1'b0;
    inValid = 1'b0;
    resReady = 1'b1;
    inA = '0;
    inB = '0;
`ifdef RED_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkLanes("rst_in_ready", inReadyV, 3'b111);
    checkLanes("rst_res_valid", resValidV, 3'b000);
    checkLanes("rst_busy", busyV, 3'b000);
    checkSums("rst_sum", 0);

    for (int i = 0; i < 6; i++)
      runOp(vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));
    checkSums("sum_held", 47);

    // Backpressure: result held in DONE, new operands refused.
    inA = 16'h1111;
    inB = 16'h2222;
    inValid = 1'b1;
    resReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      inA = 16'hFFFF;
      inB = 16'h0000;
      inValid = 1'b1;
      @(posedge clk); #1;
      checkLanes($sformatf("bp%0d_valid", c), resValidV, 3'b111);
      checkLanes($sformatf("bp%0d_ready", c), inReadyV, 3'b000);
      checkSums($sformatf("bp%0d_sum", c), 12);
    end
    resReady = 1'b1;
    @(posedge clk); #1;
    checkLanes("bp_release_valid", resValidV, 3'b000);
    checkLanes("bp_release_ready", inReadyV, 3'b111);
    checkLanes("bp_release_busy", busyV, 3'b000);
    @(posedge clk); #1;
    inValid = 1'b0;
    checkLanes("bp_next_busy", busyV, 3'b111);
    repeat (6) @(posedge clk);
    #1;
    checkSums("bp_next_sum", 60);
    checkLanes("bp_next_idle", busyV, 3'b000);

`ifdef RED_FLUSH_EN
    // Flush during ACCUM: no result, sum unchanged.
    inA = 16'h1234;
    inB = 16'h5678;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkLanes("fl_accum_busy", busyV, 3'b000);
    checkLanes("fl_accum_valid", resValidV, 3'b000);
    vCount = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      vCount += int'(resValidV != 3'b000);
    end
    check("fl_accum_no_result", vCount, 0);
    checkSums("fl_accum_sum", 60);

    // Flush beats res_ready in DONE.
    inA = 16'h1111;
    inB = 16'h2222;
    inValid = 1'b1;
    resReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkLanes("fl_done_pre_valid", resValidV, 3'b111);
    flush = 1'b1;
    resReady = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkLanes("fl_done_valid", resValidV, 3'b000);
    checkLanes("fl_done_busy", busyV, 3'b000);
    checkSums("fl_done_sum", 12);

    // Flush in IDLE blocks the accept.
    flush = 1'b1;
    inValid = 1'b1;
    #1;
    checkLanes("fl_idle_ready", inReadyV, 3'b000);
    @(posedge clk); #1;
    checkLanes("fl_idle_busy", busyV, 3'b000);
    flush = 1'b0;
    inValid = 1'b0;
    @(posedge clk); #1;
`endif

    // Async reset during the second ACCUM cycle.
    inA = 16'hFFFF;
    inB = 16'hFFFF;
    inValid = 1'b1;
    resReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkLanes("arst_ready", inReadyV, 3'b111);
    checkLanes("arst_valid", resValidV, 3'b000);
    checkLanes("arst_busy", busyV, 3'b000);
    checkSums("arst_sum", 0);
    vCount = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      vCount += int'(resValidV != 3'b000);
    end
    check("arst_no_result", vCount, 0);
    rst_n = 1'b1;
    resReady = 1'b1;
    runOp(16'h1234, 16'h5678, 36, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/red_seq.md
Name: red_seq

Overview:
- Multi-cycle sequencer for the RED (nibble-reduction) operation.
- Reduces two 16-bit operands to the unsigned sum of all eight 4-bit nibbles, reusing one narrow nibble-adder slice over several cycles instead of a full adder tree.
- Sits beside the execute stage as a shared multi-cycle unit, with valid/ready handshakes on operand and result sides.

Parameters:
- LANES, 1: nibble pairs summed per cycle; legal values are 1, 2 and 4. Accumulate cycles = 4/LANES.
- RES_W, 16: result width; the sum is zero-extended to this width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands offered.
- in_ready  out  1  unit can accept operands.
- in_a  in  16  operand A.
- in_b  in  16  operand B.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_sum  out  RES_W  reduction result.
- busy  out  1  state != IDLE.
- flush  in  1  cancel in-flight op; present only with RED_FLUSH_EN.

Behaviour:
- Reset (async, rst_n low): state=IDLE, in_ready=1, res_valid=0, res_sum=0, busy=0, internal idx=0, acc=0.
  - Reset mid-operation discards the op; no result is produced.
- Arithmetic:
  - result = sum over i=0..3 of A[4i+3:4i] + B[4i+3:4i], all unsigned.
  - Max value 8*15 = 120; a 7-bit accumulator suffices. res_sum is zero-extended to RES_W and never wraps.
- States:
  - IDLE: in_ready=1. On the in_valid&&in_ready edge, latch in_a/in_b, set acc=0, idx=0, go to ACCUM. in_valid while not in IDLE is ignored (in_ready=0).
  - ACCUM: each edge adds LANES nibble pairs starting at idx to acc, then idx += LANES. On the edge consuming the last pair (idx+LANES == 4), write acc+partial to res_sum and go to DONE. Operand registers stay stable.
  - DONE: res_valid=1; res_sum held stable. On the res_valid&&res_ready edge, go to IDLE and clear res_valid. res_sum keeps its last value until the next DONE.
- Latency:
  - res_valid rises exactly 4/LANES edges after the accept edge: 4 for LANES=1, 2 for LANES=2, 1 for LANES=4.
  - Minimum accept-to-accept spacing is 4/LANES+2 cycles.
- Simultaneous events: no accept is possible in DONE, even if res_ready is high that cycle; the next accept happens from IDLE.
- Backpressure: DONE holds indefinitely while res_ready=0.

Optional Feature:
- Macro RED_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush=1 at an edge in ACCUM or DONE forces IDLE, res_valid=0, acc=0; res_sum is unchanged.
  - flush in IDLE blocks the accept that cycle (in_ready = ~flush).
  - flush has priority over accept and over result consume.
- Undefined: no flush port; behaviour is exactly as above.

Decomposition:
- Package red_pkg holds:
  - state typedef (IDLE, ACCUM, DONE), 2-bit encoding;
  - NIBBLE_W=4, NUM_PAIRS=4, ACC_W=7;
  - a function returning cycle count from LANES.
- One combinational sub-module, red_lane_adder: takes LANES nibble pairs plus acc and returns the new acc. All state lives in red_seq.

Test Plan:
- LANES=1, A=16'h1234, B=16'h5678, res_ready=1 → res_valid 4 edges after accept, res_sum=16'h0024 (36), busy high for 5 cycles.
- A=16'hFFFF, B=16'hFFFF → res_sum=16'h0078 (120); A=B=0 → 16'h0000.
- Backpressure: res_ready=0 for 3 cycles in DONE → res_valid/res_sum stable, in_ready=0 and a new in_valid is not taken; raise res_ready → IDLE the next cycle, then accept the next op.
- Rerun the first two cases with LANES=2 and LANES=4 → identical sums, latency 2 and 1 respectively.
- Drop rst_n asynchronously during the 2nd ACCUM cycle → outputs reach reset values immediately, no res_valid pulse; the next op after release computes correctly.
- With RED_FLUSH_EN: flush during ACCUM → IDLE, no result; flush coincident with res_ready in DONE → IDLE, res_valid=0; flush with in_valid in IDLE → no accept.
